orpsoc_sim_mailbox: RTL and testbench

Wishbone slave that lets software running on the OR1200 push results out to the simulation bench. Software writes characters, report values and an exit code to memory-mapped registers. The block buffers characters in a FIFO and presents them, the report pulses and the exit status on a bench-side streaming interface. It sits on the SoC data bus and is the software-driven counterpart to instruction-stream monitoring, replacing magic l.nop decoding for bus-capable test programs.

---
 rtl/orpsoc_mailbox_pkg.sv | 33 +++
 rtl/orpsoc_sim_mailbox_if.sv | 28 ++
 rtl/orpsoc_mailbox_fifo.sv | 61 ++++++
 rtl/orpsoc_sim_mailbox.sv | 194 +++++++++++++++++++
 tb/tb_orpsoc_sim_mailbox.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/orpsoc_mailbox_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | orpsoc_mailbox_pkg                                                 |
// | Register indices, STATUS bit positions and bus states for mailbox. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package orpsoc_mailbox_pkg;

  localparam logic [2:0] c_REG_PUTC    = 3'd0;
  localparam logic [2:0] c_REG_REPORT  = 3'd1;
  localparam logic [2:0] c_REG_EXIT    = 3'd2;
  localparam logic [2:0] c_REG_CYCLE   = 3'd3;
  localparam logic [2:0] c_REG_STATUS  = 3'd4;
  localparam logic [2:0] c_REG_SCRATCH = 3'd5;

  localparam int c_STAT_EMPTY    = 0;
  localparam int c_STAT_FULL     = 1;
  localparam int c_STAT_OVERFLOW = 2;
  localparam int c_STAT_EXIT     = 3;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2
  } bus_state_e;

  // Indices above SCRATCH are unmapped and terminate with an error.
  function automatic logic reg_is_err(input logic [2:0] idx);
    return (idx > c_REG_SCRATCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/orpsoc_sim_mailbox_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | orpsoc_sim_mailbox_if                                              |
// | Classic Wishbone bus bundle with master and slave views.           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface orpsoc_sim_mailbox_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/orpsoc_mailbox_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | orpsoc_mailbox_fifo                                                |
// | Synchronous power-of-two FIFO; a push into a full FIFO is accepted |
// | only when a pop happens in the same cycle.                         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module orpsoc_mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (c_AW+1)'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // Head is forced to zero while empty so the output is clean out of reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/orpsoc_sim_mailbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | orpsoc_sim_mailbox                                                 |
// | Wishbone mailbox carrying characters, reports and exit status from |
// | software to the bench. Option: MAILBOX_PUTC_STALL_EN (stall PUTC   |
// | on a full FIFO instead of dropping the byte).                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module orpsoc_sim_mailbox
  import orpsoc_mailbox_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CYC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  orpsoc_sim_mailbox_if.slave  wb,
  output logic                 char_valid_o,
  output logic [7:0]           char_data_o,
  input  logic                 char_ready_i,
  output logic                 report_valid_o,
  output logic [31:0]          report_data_o,
  output logic                 exit_o,
  output logic [31:0]          exit_code_o
);

  localparam int         c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] c_S_IDLE = BUS_IDLE;
  localparam logic [1:0] c_S_WAIT = BUS_WAIT;
  localparam logic [1:0] c_S_ACK  = BUS_ACK;

  logic [1:0]       r_state;
  logic             r_ack;
  logic             r_err;
  logic             r_we;
  logic [2:0]       r_idx;
  logic [31:0]      r_wdat;
  logic [3:0]       r_sel;
  logic [31:0]      r_rdata;
  logic [CYC_W-1:0] r_cycle;
  logic             r_overflow;
  logic [31:0]      r_scratch;
  logic [31:0]      r_report_data;
  logic             r_report_valid;
  logic             r_exit;
  logic [31:0]      r_exit_code;

  logic             w_req;
  logic [2:0]       w_idx;
  logic             w_is_err;
  logic             w_putc_block;
  logic             w_go_ack;
  logic             w_commit;
  logic             w_push;
  logic             w_pop;
  logic             w_overflow_set;
  logic             w_full;
  logic             w_empty;
  logic [c_CNT_W-1:0] w_count;
  logic [7:0]       w_head;
  logic [31:0]      w_rdata;
  logic             w_unused_adr;

  assign w_req        = wb.wb_cyc & wb.wb_stb;
  assign w_idx        = wb.wb_adr[4:2];
  assign w_is_err     = reg_is_err(w_idx);
  assign w_unused_adr = ^{wb.wb_adr[31:5], wb.wb_adr[1:0]};
  assign w_pop        = ~w_empty & char_ready_i;

  // r_ack is only ever high in ACK, so it doubles as the commit strobe.
  assign w_commit = r_ack & r_we;
  assign w_push   = w_commit & (r_idx == c_REG_PUTC) & (r_sel != 4'd0);

`ifdef MAILBOX_PUTC_STALL_EN
  assign w_putc_block   = w_req & wb.wb_we & (w_idx == c_REG_PUTC) &
                          (wb.wb_sel != 4'd0) & w_full & ~w_pop;
  assign w_overflow_set = 1'b0;
`else
  assign w_putc_block   = 1'b0;
  assign w_overflow_set = w_push & w_full & ~w_pop;
`endif

  assign w_go_ack = w_req & ~w_putc_block &
                    ((r_state == c_S_IDLE) | (r_state == c_S_WAIT));

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      c_REG_PUTC:    w_rdata = 32'(w_count);
      c_REG_REPORT:  w_rdata = r_report_data;
      c_REG_EXIT:    w_rdata = r_exit_code;
      c_REG_CYCLE:   w_rdata = 32'(r_cycle);
      c_REG_STATUS:  w_rdata = {28'd0, r_exit, r_overflow, w_full, w_empty};
      c_REG_SCRATCH: w_rdata = r_scratch;
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdat  <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_go_ack & ~w_is_err;
      r_err <= w_go_ack & w_is_err;
      if (w_go_ack) begin
        r_state <= c_S_ACK;
        r_we    <= wb.wb_we;
        r_idx   <= w_idx;
        r_wdat  <= wb.wb_dat_w;
        r_sel   <= wb.wb_sel;
        r_rdata <= w_is_err ? 32'd0 : w_rdata;
      end else begin
        case (r_state)
          c_S_IDLE: if (w_req) r_state <= c_S_WAIT;
          c_S_WAIT: if (!w_req) r_state <= c_S_IDLE;
          default:  r_state <= c_S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle        <= '0;
      r_overflow     <= 1'b0;
      r_scratch      <= '0;
      r_report_data  <= '0;
      r_report_valid <= 1'b0;
      r_exit         <= 1'b0;
      r_exit_code    <= '0;
    end else begin
      r_cycle        <= r_cycle + CYC_W'(1);
      r_report_valid <= 1'b0;
      if (w_commit) begin
        case (r_idx)
          c_REG_REPORT: begin
            r_report_data  <= r_wdat;
            r_report_valid <= 1'b1;
          end
          c_REG_EXIT: begin
            if (!r_exit) begin
              r_exit      <= 1'b1;
              r_exit_code <= r_wdat;
            end
          end
          c_REG_STATUS: begin
            if (r_wdat[c_STAT_OVERFLOW]) r_overflow <= 1'b0;
          end
          c_REG_SCRATCH: begin
            for (int b = 0; b < 4; b++) begin
              if (r_sel[b]) r_scratch[8*b +: 8] <= r_wdat[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
      if (w_overflow_set) r_overflow <= 1'b1;
    end
  end

  orpsoc_mailbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_wdat[7:0]),
    .i_pop   (char_ready_i),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wb.wb_ack      = r_ack;
  assign wb.wb_err      = r_err;
  assign wb.wb_dat_r    = r_ack ? r_rdata : 32'd0;
  assign char_valid_o   = ~w_empty;
  assign char_data_o    = w_head;
  assign report_valid_o = r_report_valid;
  assign report_data_o  = r_report_data;
  assign exit_o         = r_exit;
  assign exit_code_o    = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_orpsoc_sim_mailbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_orpsoc_sim_mailbox                                              |
// | Directed and randomized bench with a queue-based reference model.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_orpsoc_sim_mailbox;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  orpsoc_sim_mailbox_if wb();

  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        report_valid;
  logic [31:0] report_data;
  logic        exit_flag;
  logic [31:0] exit_code;

  orpsoc_sim_mailbox #(
    .FIFO_DEPTH (DEPTH),
    .CYC_W      (32)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb             (wb),
    .char_valid_o   (char_valid),
    .char_data_o    (char_data),
    .char_ready_i   (char_ready),
    .report_valid_o (report_valid),
    .report_data_o  (report_data),
    .exit_o         (exit_flag),
    .exit_code_o    (exit_code)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Reference model state
  int          m_level;
  bit          m_ovf;
  bit          m_exit;
  logic [31:0] m_exit_code;
  logic [31:0] m_scratch;

  always @(posedge clk) begin
    if (rst_n && char_valid && char_ready) rx_q.push_back(char_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_exit, m_ovf, (m_level == DEPTH), (m_level == 0)};
  endfunction

  task automatic bus(input logic we, input logic [2:0] idx, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd,
                     output logic ack, output logic err);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = idx;
    a[1:0] = 2'b00;
    wb.wb_adr = a;
    wb.wb_dat_w = d;
    wb.wb_sel = sel;
    wb.wb_we = we;
    wb.wb_cyc = 1'b1;
    wb.wb_stb = 1'b1;
    rd = '0; ack = 1'b0; err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (wb.wb_ack || wb.wb_err) begin
        ack = wb.wb_ack; err = wb.wb_err; rd = wb.wb_dat_r;
        break;
      end
    end
    wb.wb_cyc = 1'b0;
    wb.wb_stb = 1'b0;
    wb.wb_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] rd; logic ack, err;
    bus(1'b1, idx, d, sel, rd, ack, err);
    chk("write_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic rdreg(input logic [2:0] idx, output logic [31:0] v);
    logic ack, err;
    bus(1'b0, idx, $urandom(), 4'hF, v, ack, err);
    chk("read_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic putc(input logic [7:0] c, input logic [3:0] sel);
    wr(3'd0, {$urandom_range(0, 255), 16'h0, c}, sel);
    if (sel != 4'd0) begin
      if (m_level < DEPTH) begin
        exp_q.push_back(c);
        m_level++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic drain_and_compare(input string tag);
    char_ready = 1'b1;
    repeat (DEPTH + 6) @(posedge clk);
    #1;
    m_level = 0;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] v, v2;
    logic ack, err, saw_ack;
    logic [7:0] c;
    int k;

    wb.wb_adr = '0; wb.wb_dat_w = '0; wb.wb_sel = '0;
    wb.wb_we = 1'b0; wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    char_ready = 1'b0;
    m_level = 0; m_ovf = 0; m_exit = 0; m_exit_code = '0; m_scratch = '0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_outputs",
        {char_valid, char_data, report_valid, exit_flag, wb.wb_ack, wb.wb_err},
        32'd0);
    chk("rst_report_data", report_data, 32'd0);
    chk("rst_exit_code", exit_code, 32'd0);
    chk("rst_dat_o", wb.wb_dat_r, 32'd0);

    rdreg(3'd3, v);
    rdreg(3'd3, v2);
    chk("cycle_delta", v2, v + 32'd2);

    // Hello sequence with the bench always ready
    char_ready = 1'b1;
    putc(8'h48, 4'hF);
    putc(8'h69, 4'h1);
    repeat (4) @(posedge clk);
    m_level = 0;
    rdreg(3'd0, v);
    chk("level_after_hi", v, 32'd0);
    drain_and_compare("hi");

    char_ready = 1'b0;
    putc(8'h77, 4'h0);
    rdreg(3'd0, v);
    chk("sel0_putc_level", v, m_level);

    k = $urandom_range(3, 8);
    for (int i = 0; i < k; i++) putc(8'($urandom()), 4'($urandom_range(1, 15)));
    rdreg(3'd0, v);
    chk("rand_level", v, m_level);
    rdreg(3'd4, v);
    chk("rand_status", v, m_status());
    drain_and_compare("rand");

    char_ready = 1'b0;
`ifndef MAILBOX_PUTC_STALL_EN
    for (int i = 0; i < DEPTH + 1; i++) putc(8'($urandom()), 4'h1);
    rdreg(3'd0, v);
    chk("full_level", v, 32'(DEPTH));
    rdreg(3'd4, v);
    chk("full_status", v, 32'h6);
    wr(3'd4, 32'h4, 4'hF);
    m_ovf = 1'b0;
    rdreg(3'd4, v);
    chk("ovf_cleared", v, m_status());
`else
    for (int i = 0; i < DEPTH; i++) putc(8'($urandom()), 4'h1);
    c = 8'($urandom());
    wb.wb_adr = 32'h0; wb.wb_dat_w = {24'd0, c}; wb.wb_sel = 4'h1;
    wb.wb_we = 1'b1; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
    saw_ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_ack = saw_ack | wb.wb_ack;
    end
    chk("stall_no_ack", {31'd0, saw_ack}, 32'd0);
    char_ready = 1'b1;
    @(posedge clk); #1;
    char_ready = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (wb.wb_ack) begin saw_ack = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("stall_ack", {31'd0, saw_ack}, 32'd1);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    exp_q.push_back(c);
    repeat (2) @(posedge clk);
    rdreg(3'd0, v);
    chk("stall_level", v, 32'(DEPTH));
    rdreg(3'd4, v);
    chk("stall_status", v, 32'h2);
`endif
    drain_and_compare("full");

    wr(3'd2, 32'h0, 4'hF);
    wr(3'd2, 32'h5, 4'hF);
    m_exit = 1'b1; m_exit_code = 32'h0;
    chk("exit_flag", {31'd0, exit_flag}, 32'd1);
    chk("exit_code", exit_code, m_exit_code);
    rdreg(3'd2, v);
    chk("exit_read", v, m_exit_code);
    rdreg(3'd4, v);
    chk("exit_status", v, m_status());

    wr(3'd1, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    chk("report_pulse", {31'd0, report_valid}, 32'd1);
    chk("report_data", report_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("report_pulse_end", {31'd0, report_valid}, 32'd0);
    rdreg(3'd1, v);
    chk("report_read", v, 32'hDEADBEEF);
    v2 = $urandom();
    wr(3'd1, v2, 4'($urandom()));
    rdreg(3'd1, v);
    chk("report_rand", v, v2);

    wr(3'd5, 32'h11223344, 4'h4);
    m_scratch = 32'h00220000;
    rdreg(3'd5, v);
    chk("scratch_lane", v, m_scratch);
    bus(1'b1, 3'd6, 32'hFFFFFFFF, 4'hF, v, ack, err);
    chk("err6_err", {31'd0, err}, 32'd1);
    chk("err6_ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    chk("err_one_cycle", {31'd0, wb.wb_err}, 32'd0);
    bus(1'b0, 3'd7, 32'h0, 4'hF, v, ack, err);
    chk("err7_data", {v[30:0], err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d; logic [3:0] s;
      d = $urandom(); s = 4'($urandom());
      wr(3'd5, d, s);
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end
    rdreg(3'd5, v);
    chk("scratch_rand", v, m_scratch);

    wb.wb_adr = 32'h4; wb.wb_we = 1'b0; wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_abandon", {30'd0, wb.wb_ack, exit_flag}, 32'd0);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
